// File: rtl/rf_multiport.sv
// Parametrised multi-port register file with a post-reset clear sequencer, a registered debug port and a write-commit monitor.
// Define RF_BYPASS_EN to forward committing write data onto the combinational read ports.
module rf_multiport #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int INIT_INDEX = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              wr_inhibit,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              busy,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] last_wa,
   output logic [DATA_W-1:0] last_wd,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   idx_q;
   logic                busy_q;
   logic [DATA_W-1:0]   rf_q [DEPTH];
   logic [DATA_W-1:0]   dbg_data_q;
   logic                wr_ack_q;
   logic [ADDR_W-1:0]   last_wa_q;
   logic [DATA_W-1:0]   last_wd_q;
   logic [CNT_W-1:0]    wr_count_q;

   logic                commit;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_wa_d;
   logic [DATA_W-1:0]   mem_wd_d;
   logic [DATA_W-1:0]   init_val;

   assign commit = (state_q == S_READY) && we && !wr_inhibit && (wa != '0);

   always_comb begin
      init_val = (INIT_INDEX != 0) ? DATA_W'(idx_q) : '0;
   end

   // The sequencer owns the write port while clearing; datapath writes only land in READY.
   always_comb begin
      mem_we_d = 1'b0;
      mem_wa_d = wa;
      mem_wd_d = wd;
      if (state_q == S_CLEAR) begin
         mem_we_d = 1'b1;
         mem_wa_d = idx_q;
         mem_wd_d = init_val;
      end else if (commit) begin
         mem_we_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_we_d) begin
         rf_q[mem_wa_d] <= mem_wd_d;
      end
   end

   // idx_q is all-ones exactly at DEPTH-1 since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         idx_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (idx_q == '1) begin
                  state_q <= S_READY;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= S_READY;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ack_q   <= 1'b0;
         last_wa_q  <= '0;
         last_wd_q  <= '0;
         wr_count_q <= '0;
         dbg_data_q <= '0;
      end else begin
         wr_ack_q   <= commit;
         dbg_data_q <= (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
         if (commit) begin
            last_wa_q <= wa;
            last_wd_q <= wd;
            if (wr_count_q != '1) begin
               wr_count_q <= wr_count_q + CNT_W'(1);
            end
         end
      end
   end

`ifdef RF_BYPASS_EN
   always_comb begin
      rd1 = rf_q[ra1];
      rd2 = rf_q[ra2];
      if (commit && (ra1 == wa)) rd1 = wd;
      if (commit && (ra2 == wa)) rd2 = wd;
      if (busy_q || (ra1 == '0)) rd1 = '0;
      if (busy_q || (ra2 == '0)) rd2 = '0;
   end
`else
   always_comb begin
      rd1 = (busy_q || (ra1 == '0)) ? '0 : rf_q[ra1];
      rd2 = (busy_q || (ra2 == '0)) ? '0 : rf_q[ra2];
   end
`endif

   assign busy     = busy_q;
   assign dbg_data = dbg_data_q;
   assign wr_ack   = wr_ack_q;
   assign last_wa  = last_wa_q;
   assign last_wd  = last_wd_q;
   assign wr_count = wr_count_q;

endmodule
